// File: rtl/fft_bundle_packer.sv
// fft_bundle_packer
//   Front-end producer for the parallel radix-2 butterfly stage. Collects a
//   serial stream of complex samples (R/Q, WIDTH-bit signed) into DEPTH-lane
//   bundles. Two banks (A/B) ping-pong so that one sample per cycle can be
//   accepted while the previous bundle is held for the butterfly.
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous, active-high reset
//     in_valid   input sample present
//     in_ready   packer can accept a sample this cycle (fill bank not FULL)
//     in_R/in_Q  signed sample, real / imaginary
//     in_last    final sample of a frame (early close when cnt < DEPTH-1)
//     out_valid  drain bank is FULL; gated by out_ready it is the butterfly en
//     out_ready  consumer takes the bundle this cycle
//     out_R/Q    DEPTH lanes of WIDTH-bit signed data (butterfly din_R/din_Q)
//     err_short  one-cycle pulse the cycle after an early frame close
//
//   Build option
//     FFT_BUNDLE_PACKER_BITREV_EN  defined: sample k is written to lane
//     bitrev(k) over log2(DEPTH) bits. Undefined: lane k. Nothing else changes.

module fft_bundle_lane #(
  parameter int WIDTH = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,      // this lane is written this cycle
  input  logic                    fill_ptr,   // bank being written
  input  logic                    close,      // frame closes this cycle
  input  logic                    drain_ptr,  // bank being presented
  input  logic                    out_valid,
  input  logic                    hs,         // out_valid && out_ready
  input  logic signed [WIDTH-1:0] din_R,
  input  logic signed [WIDTH-1:0] din_Q,
  output logic signed [WIDTH-1:0] dout_R,
  output logic signed [WIDTH-1:0] dout_Q
);

  logic signed [WIDTH-1:0] bank_R [2];
  logic signed [WIDTH-1:0] bank_Q [2];
  logic signed [WIDTH-1:0] hold_R, hold_Q;
  // Lane written during the frame currently filling, per bank. Unwritten
  // lanes are zeroed on the closing edge, so short frames never leak stale data.
  logic [1:0]              written;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        bank_R[b] <= '0;
        bank_Q[b] <= '0;
      end
      written <= '0;
      hold_R  <= '0;
      hold_Q  <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (fill_ptr == 1'(b)) begin
          if (wr_en) begin
            bank_R[b] <= din_R;
            bank_Q[b] <= din_Q;
          end else if (close && !written[b]) begin
            bank_R[b] <= '0;
            bank_Q[b] <= '0;
          end
          if (close)      written[b] <= 1'b0;
          else if (wr_en) written[b] <= 1'b1;
        end
      end
      // The drained bank may be refilled right away; keep a copy so the
      // outputs hold still while nothing is valid.
      if (hs) begin
        hold_R <= bank_R[drain_ptr];
        hold_Q <= bank_Q[drain_ptr];
      end
    end
  end

  assign dout_R = out_valid ? bank_R[drain_ptr] : hold_R;
  assign dout_Q = out_valid ? bank_Q[drain_ptr] : hold_Q;

endmodule

module fft_bundle_packer #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic signed [WIDTH-1:0]            in_R,
  input  logic signed [WIDTH-1:0]            in_Q,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic signed [DEPTH-1:0][WIDTH-1:0] out_R,
  output logic signed [DEPTH-1:0][WIDTH-1:0] out_Q,
  output logic                               err_short
);

  localparam int LG = $clog2(DEPTH);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  if (DEPTH < 2 || (1 << LG) != DEPTH) begin : g_depth_chk
    $error("fft_bundle_packer: DEPTH must be a power of two >= 2");
  end

  logic [1:0]    bank_st [2];
  logic          fill_ptr, drain_ptr;
  logic [LG-1:0] cnt, wr_addr;
  logic          acc, last_lane, close, hs;

  assign in_ready  = (bank_st[fill_ptr] != ST_FULL);
  assign out_valid = (bank_st[drain_ptr] == ST_FULL);
  assign acc       = in_valid && in_ready;
  assign last_lane = (cnt == LG'(DEPTH - 1));
  assign close     = acc && (last_lane || in_last);
  assign hs        = out_valid && out_ready;

`ifdef FFT_BUNDLE_PACKER_BITREV_EN
  always_comb begin
    wr_addr = '0;
    for (int i = 0; i < LG; i++) wr_addr[i] = cnt[LG-1-i];
  end
`else
  assign wr_addr = cnt;
`endif

  // Fill and drain never address the same bank in one cycle: the fill bank
  // is not FULL when accepting and the drain bank is FULL when handing off.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st[0] <= ST_EMPTY;
      bank_st[1] <= ST_EMPTY;
      fill_ptr   <= 1'b0;
      drain_ptr  <= 1'b0;
      cnt        <= '0;
      err_short  <= 1'b0;
    end else begin
      if (acc) begin
        bank_st[fill_ptr] <= close ? ST_FULL : ST_FILLING;
        cnt               <= close ? '0 : cnt + 1'b1;
        if (close) fill_ptr <= ~fill_ptr;
      end
      if (hs) begin
        bank_st[drain_ptr] <= ST_EMPTY;
        drain_ptr          <= ~drain_ptr;
      end
      err_short <= close && !last_lane;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_lane
    fft_bundle_lane #(.WIDTH(WIDTH)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (acc && (wr_addr == LG'(i))),
      .fill_ptr  (fill_ptr),
      .close     (close),
      .drain_ptr (drain_ptr),
      .out_valid (out_valid),
      .hs        (hs),
      .din_R     (in_R),
      .din_Q     (in_Q),
      .dout_R    (out_R[i]),
      .dout_Q    (out_Q[i])
    );
  end

endmodule

// File: tb/tb_fft_bundle_packer.sv
// Bench for fft_bundle_packer (WIDTH=9, DEPTH=16). A queue-based reference
// model (at most two completed bundles outstanding, frame buffer zeroed at
// frame start) is checked every cycle; directed sequences add constant checks.
module tb_fft_bundle_packer;
  localparam int WIDTH = 9;
  localparam int DEPTH = 16;
  localparam int LG    = 4;
  localparam int VW    = DEPTH * WIDTH;

  typedef logic [DEPTH-1:0][WIDTH-1:0] bund_t;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_last, out_valid, out_ready, err_short;
  logic signed [WIDTH-1:0] in_R, in_Q;
  logic signed [DEPTH-1:0][WIDTH-1:0] out_R, out_Q;

  always #5 clk = ~clk;

  fft_bundle_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_R(in_R), .in_Q(in_Q), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_R(out_R), .out_Q(out_Q), .err_short(err_short)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, logic [VW-1:0] act, logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int addr(int k);
    int r;
    r = 0;
`ifdef FFT_BUNDLE_PACKER_BITREV_EN
    for (int i = 0; i < LG; i++) if (k & (1 << i)) r |= 1 << (LG - 1 - i);
`else
    r = k;
`endif
    return r;
  endfunction

  // ---- reference model ----
  bund_t mq_r[$];
  bund_t mq_q[$];
  bund_t fr_r, fr_q, hold_r, hold_q;
  int    mk;
  logic  m_err;

  task automatic model_reset();
    mq_r.delete(); mq_q.delete();
    fr_r = '0; fr_q = '0; hold_r = '0; hold_q = '0;
    mk = 0; m_err = 1'b0;
  endtask

  task automatic model_tick();
    bit acc, pop;
    int qs;
    if (rst) begin
      model_reset();
      return;
    end
    qs    = mq_r.size();
    acc   = in_valid && (qs < 2);
    pop   = (qs > 0) && out_ready;
    m_err = 1'b0;
    if (pop) begin
      hold_r = mq_r.pop_front();
      hold_q = mq_q.pop_front();
    end
    if (acc) begin
      fr_r[addr(mk)] = in_R;
      fr_q[addr(mk)] = in_Q;
      if (mk == DEPTH - 1 || in_last) begin
        mq_r.push_back(fr_r);
        mq_q.push_back(fr_q);
        m_err = (mk != DEPTH - 1);
        fr_r = '0; fr_q = '0; mk = 0;
      end else begin
        mk++;
      end
    end
  endtask

  // Compare outputs with the model, advance the model with the current
  // inputs, then clock once and settle.
  task automatic step();
    chk("in_ready",  VW'(in_ready),  VW'(mq_r.size() < 2));
    chk("out_valid", VW'(out_valid), VW'(mq_r.size() > 0));
    chk("err_short", VW'(err_short), VW'(m_err));
    chk("out_R", out_R, (mq_r.size() > 0) ? mq_r[0] : hold_r);
    chk("out_Q", out_Q, (mq_q.size() > 0) ? mq_q[0] : hold_q);
    model_tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic v; int r; int q; logic last; logic ordy; logic e_ir; logic e_ov;
  } vec_t;
  vec_t tv[18];

  bund_t b2_r;

  initial begin
    for (int k = 0; k < DEPTH; k++)
      tv[k] = '{1'b1, k * 3, (15 - k) * 2, 1'b0, 1'b1, 1'b1, 1'b0};
    tv[16] = '{1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1};
    tv[17] = '{1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0};

    // ---- reset, 2 cycles with in_valid high ----
    rst = 1'b1; in_valid = 1'b1; in_R = 9'sd5; in_Q = 9'sd6; in_last = 1'b0; out_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_in_ready",  VW'(in_ready),  VW'(1));
    chk("rst_out_valid", VW'(out_valid), VW'(0));
    chk("rst_err_short", VW'(err_short), VW'(0));
    chk("rst_lanes_R", out_R, '0);
    chk("rst_lanes_Q", out_Q, '0);

    // ---- streaming, table driven ----
    for (int i = 0; i < 18; i++) begin
      in_valid = tv[i].v; in_R = 9'(tv[i].r); in_Q = 9'(tv[i].q);
      in_last = tv[i].last; out_ready = tv[i].ordy;
      chk("tv_in_ready",  VW'(in_ready),  VW'(tv[i].e_ir));
      chk("tv_out_valid", VW'(out_valid), VW'(tv[i].e_ov));
      if (i == 16) begin
`ifdef FFT_BUNDLE_PACKER_BITREV_EN
        chk("stream_R5", VW'(out_R[5]), VW'(30));
        chk("stream_Q5", VW'(out_Q[5]), VW'(10));
`else
        chk("stream_R5", VW'(out_R[5]), VW'(15));
        chk("stream_Q5", VW'(out_Q[5]), VW'(20));
`endif
      end
      step();
    end

    // ---- backpressure: 32 samples with out_ready low ----
    out_ready = 1'b0; in_last = 1'b0;
    b2_r = '0;
    for (int k = 0; k < 32; k++) begin
      in_valid = 1'b1; in_R = 9'($urandom); in_Q = 9'($urandom);
      if (k >= 16) b2_r[addr(k - 16)] = in_R;
      if (k == 31) chk("bp_ready_before_31", VW'(in_ready), VW'(1));
      step();
    end
    chk("bp_ready_low", VW'(in_ready), VW'(0));
    step(); step();              // blocked attempts, must not be taken
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_valid_kept", VW'(out_valid), VW'(1));
    chk("bp_ready_back", VW'(in_ready), VW'(1));
    chk("bp_bundle2", out_R, b2_r);
    out_ready = 1'b1; step(); step(); out_ready = 1'b0;

    // ---- boundary values ----
    for (int k = 0; k < DEPTH; k++) begin
      in_valid = 1'b1;
      in_R = (k < 2) ? 9'sd255 : (k < 4) ? -9'sd256 : 9'(k + 3);
      in_Q = -9'(k);
      step();
    end
    in_valid = 1'b0;
    chk("bnd_R0",  VW'(out_R[addr(0)]), VW'(9'h0ff));
    chk("bnd_R2",  VW'(out_R[addr(2)]), VW'(9'h100));
    chk("bnd_R15", VW'(out_R[15]), VW'(18));
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // ---- short frame: in_last on k=5 ----
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_R = 9'(k + 1); in_Q = -9'(k + 1); in_last = (k == 5);
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("short_err_pulse", VW'(err_short), VW'(1));
    chk("short_valid", VW'(out_valid), VW'(1));
    for (int k = 6; k < DEPTH; k++) begin
      chk("short_zero_R", VW'(out_R[addr(k)]), VW'(0));
      chk("short_zero_Q", VW'(out_Q[addr(k)]), VW'(0));
    end
    out_ready = 1'b1; step();
    chk("short_err_off", VW'(err_short), VW'(0));
    in_valid = 1'b1; in_R = 9'sd77; in_Q = 9'sd1; in_last = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    chk("short_next_lane0", VW'(out_R[0]), VW'(77));
    chk("short_next_err", VW'(err_short), VW'(1));
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // ---- lane ordering, R = k ----
    for (int k = 0; k < DEPTH; k++) begin
      in_valid = 1'b1; in_R = 9'(k); in_Q = 9'(2 * k);
      step();
    end
    in_valid = 1'b0;
`ifdef FFT_BUNDLE_PACKER_BITREV_EN
    chk("order_lane8",  VW'(out_R[8]),  VW'(1));
    chk("order_lane12", VW'(out_R[12]), VW'(3));
`else
    chk("order_lane1",  VW'(out_R[1]),  VW'(1));
    chk("order_lane3",  VW'(out_R[3]),  VW'(3));
`endif
    chk("order_lane15", VW'(out_R[15]), VW'(15));
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // ---- reset during backpressure ----
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1; in_R = 9'($urandom); in_Q = 9'($urandom);
      step();
    end
    rst = 1'b1; step(); rst = 1'b0; in_valid = 1'b0;
    chk("mid_rst_valid", VW'(out_valid), VW'(0));
    chk("mid_rst_ready", VW'(in_ready), VW'(1));
    chk("mid_rst_lanes", out_R, '0);
    step();

    // ---- randomized against the model ----
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_R      = 9'($urandom);
      in_Q      = 9'($urandom);
      in_last   = ($urandom_range(0, 11) == 0);
      out_ready = (i % 400 < 200) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 4) == 0);
      step();
    end
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    step(); step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_bundle_packer.md
# fft_bundle_packer

- Front-end producer for the parallel radix-2 butterfly stage.
- Collects a serial stream of complex samples (R/Q, `WIDTH`-bit signed) into `DEPTH`-lane parallel bundles and presents each completed bundle with a valid/ready handshake.
- Ping-pong double buffering sustains one accepted sample per cycle while the previous bundle is held for the butterfly.
- `out_valid` gated by `out_ready` drives the butterfly's `en`; `out_R`/`out_Q` drive its `din_R`/`din_Q`.

## Interface
- `WIDTH`, 9: signed sample width, input and output.
- `DEPTH`, 16: lanes per bundle; must be a power of two, ≥2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input sample present.
- `in_ready`  out  1  packer can accept a sample this cycle.
- `in_R`  in  `WIDTH` signed  real part.
- `in_Q`  in  `WIDTH` signed  imaginary part.
- `in_last`  in  1  marks final sample of a frame.
- `out_valid`  out  1  completed bundle presented.
- `out_ready`  in  1  consumer takes the bundle this cycle.
- `out_R`  out  `WIDTH` signed × `DEPTH`  bundle real lanes.
- `out_Q`  out  `WIDTH` signed × `DEPTH`  bundle imaginary lanes.
- `err_short`  out  1  one-cycle pulse: frame closed early by `in_last`.

## Operation
- Two banks, A and B. Each bank holds `DEPTH`×2 samples plus a state of EMPTY, FILLING or FULL.
- One fill pointer selects the bank being written. One drain pointer selects the bank presented on `out_*`.
- A sample is accepted when `in_valid && in_ready`.
  - Accepted sample k (0-based, counter `cnt` of width log2(`DEPTH`)) is written to lane `addr(k)` of the fill bank.
  - The fill bank moves to FILLING on its first write.
- Frame close happens on acceptance of sample `cnt == DEPTH-1`, or on an accepted sample with `in_last`=1, whichever comes first. On close:
  - Fill bank → FULL.
  - Lanes not yet written in this frame are forced to 0.
  - `cnt` → 0.
  - Fill pointer toggles.
- Early close (`in_last` with `cnt < DEPTH-1`): `err_short` pulses for 1 cycle, the cycle after acceptance.
- `in_last` on `cnt == DEPTH-1` is a normal close. `in_last` absent at `DEPTH-1` still closes the frame.
- `out_valid` = drain bank is FULL. `out_R`/`out_Q` are driven directly from drain-bank registers, with no combinational path from inputs.
- On `out_valid && out_ready`: drain bank → EMPTY, drain pointer toggles.
- `in_ready` = fill bank is not FULL.
- Lane order: `addr(k) = k` (see Configuration).

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `err_short`=0.
  - All `out_R`/`out_Q` lanes = 0.
  - `cnt`=0, both banks EMPTY, both pointers at A.
- Latency: `out_valid` rises on the cycle after the closing sample is accepted. Lane data is stable from that cycle until the handshake.
- Throughput: with `out_ready` held at 1, `in_ready` stays 1 continuously and one bundle is emitted every `DEPTH` cycles.
- Backpressure: with both banks FULL, `in_ready`=0. `in_ready` returns to 1 the cycle after the handshake.
- Close and drain in the same cycle:
  - The freed bank becomes fill-eligible next cycle.
  - `out_valid` stays 1 and switches to the other bank's data next cycle, with no bubble.
- `out_R`/`out_Q` hold their values while `out_valid`=0. Consumers must qualify on `out_valid`.
- Reset asserted mid-frame or mid-backpressure: everything returns to reset values the next cycle. The partial frame is discarded and nothing is emitted.
- Sample width is unchanged. No arithmetic is performed; the butterfly stage handles growth to `WIDTH+1`.

## Configuration
- Macro: `FFT_BUNDLE_PACKER_BITREV_EN`.
  - Defined: `addr(k)` = bit-reverse of k over log2(`DEPTH`) bits. For `DEPTH`=16, k=1 → lane 8 and k=3 → lane 12.
  - Not defined: natural order, `addr(k) = k`.
- The macro changes only the write addressing. Handshake, zero-fill and timing are identical in both builds. Zero-fill applies to lanes whose `addr(k)` was not written.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `in_valid`=1 → `in_ready`=1, `out_valid`=0, all lanes 0, nothing captured.
- Streaming, natural order: feed R=k*3, Q=(15-k)*2 for k=0..15 with `out_ready`=1 → `out_valid` for exactly 1 cycle, 1 cycle after k=15; `out_R[5]`=15, `out_Q[5]`=20.
- Backpressure: `out_ready`=0, feed 32 samples → `in_ready` drops after sample 31. Then `out_ready`=1 for 1 cycle → first bundle drained, `out_valid` stays 1 showing bundle 2, `in_ready`=1 next cycle.
- Boundary values: R lanes 255, 255, -256, -256, then 7..: captured bit-exact, sign preserved (`out_R[2]`=-256).
- Short frame: `in_last` on k=5 → `err_short` pulses once, lanes 6..15 = 0, next frame starts at lane 0.
- Bit-reverse build: with `FFT_BUNDLE_PACKER_BITREV_EN` defined, feed R=k → `out_R[8]`=1, `out_R[12]`=3, `out_R[15]`=15.
